// File: rtl/imem_boot_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// Defines the loader state encoding and the word-to-byte address mapping.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    localparam int WORD_BYTES = 4;

    // Byte address of word 'idx' in an image based at 'base'; 32-bit so it never wraps.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + (32'(idx) * 32'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host word stream plus instruction-memory preload port of the boot loader.
// 'slave' is the loader's view; 'master' is the host/system side that feeds words and observes writes.
interface imem_boot_loader_if;

    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        pre_ld;
    logic [31:0] pre_A;
    logic [31:0] pre_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output pre_ld,
        output pre_A,
        output pre_data
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  pre_ld,
        input  pre_A,
        input  pre_data
    );

endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: streams host words into instruction memory through the preload port,
// stalling the CPU until the image is written, and keeps a running 32-bit checksum.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int N    = 256,
    parameter int BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       len,
    imem_boot_loader_if.slave bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    localparam logic [31:0] MAX_WORDS = 32'((N - BASE) / WORD_BYTES);
    localparam logic [31:0] BASE_ADDR = 32'(BASE);

    loader_state_t state_reg;
    logic [15:0]   index_reg;
    logic [15:0]   len_reg;
    logic          pre_ld_reg;
    logic [31:0]   pre_a_reg;
    logic [31:0]   pre_data_reg;
    logic [31:0]   checksum_reg;
    logic          hold_reg;
    logic          done_reg;
    logic          err_reg;

    logic loading;
    logic accept;
    logic last_word;
    logic len_too_long;
    logic len_empty;

    assign loading      = (state_reg == LOAD);
    assign accept       = loading && bus.in_valid;
    assign last_word    = (index_reg == (len_reg - 16'd1));
    assign len_too_long = ({16'd0, len} > MAX_WORDS);
    assign len_empty    = (len == 16'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            index_reg    <= 16'd0;
            len_reg      <= 16'd0;
            pre_ld_reg   <= 1'b0;
            pre_a_reg    <= 32'd0;
            pre_data_reg <= 32'd0;
            checksum_reg <= 32'd0;
            hold_reg     <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse unless a word is accepted below.
            pre_ld_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        index_reg    <= 16'd0;
                        len_reg      <= len;
                        checksum_reg <= 32'd0;
                        hold_reg     <= 1'b1;
                        done_reg     <= 1'b0;
                        err_reg      <= 1'b0;
                        if (len_too_long) begin
                            state_reg <= ERR;
                            err_reg   <= 1'b1;
                        end else if (len_empty) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            hold_reg  <= 1'b0;
                        end else begin
                            state_reg <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        pre_ld_reg   <= 1'b1;
                        pre_a_reg    <= word_addr(BASE_ADDR, index_reg);
                        pre_data_reg <= bus.in_data;
                        checksum_reg <= checksum_reg + bus.in_data;
                        index_reg    <= index_reg + 16'd1;
                        if (last_word) begin
                            state_reg <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // The last word's write pulse is on the bus during this cycle.
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                    hold_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = loading;
    assign bus.pre_ld   = pre_ld_reg;
    assign bus.pre_A    = pre_a_reg;
    assign bus.pre_data = pre_data_reg;
    assign cpu_hold     = hold_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign checksum     = checksum_reg;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Sequences the instruction memory's preload port at boot. Accepts a stream of 32-bit instruction words over a valid/ready handshake. Writes each word little-endian at consecutive word addresses through `pre_ld`/`pre_A`/`pre_data`. Holds the processor in stall until the image is complete, then reports completion and a running checksum. It sits between the test/host interface and `instruction_memory`, which it alone drives during load.

## Interface
Parameters:
- `N`, 256: instruction memory size in bytes; must match the memory instance.
- `BASE`, 0: byte address of the first loaded word; multiple of 4, `BASE < N`.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to begin a load; sampled in IDLE, DONE, ERR only.
- `len`  in  16: number of words to load; sampled with `start`.
- `in_valid`  in  1: host word valid.
- `in_data`  in  32: host word.
- `in_ready`  out  1: loader accepts a word this cycle.
- `pre_ld`  out  1: memory write strobe, registered, one cycle per word.
- `pre_A`  out  32: memory byte address of the word being written, registered.
- `pre_data`  out  32: word being written, registered.
- `cpu_hold`  out  1: processor stall/hold; high until a load completes.
- `done`  out  1: image fully written.
- `err`  out  1: requested length exceeds memory.
- `checksum`  out  32: sum mod 2^32 of words accepted since last `start`.

## Operation
States are IDLE, LOAD, FLUSH, DONE and ERR.

- **Reset:** state IDLE. `cpu_hold`=1. `pre_ld`, `pre_A`, `pre_data`, `done`, `err`, `checksum` all 0. `in_ready`=0.
- **Start sampling:** on `start` in IDLE, DONE or ERR, `len` is checked against `MAXW = (N-BASE)/4`.
  - `len > MAXW`: go to ERR.
  - `len == 0`: go to DONE.
  - Otherwise go to LOAD.
  - In every case, clear the word index, `checksum`, `done` and `err`, and set `cpu_hold`=1.
- **LOAD:** `in_ready`=1, combinational from state. On each cycle with `in_valid && in_ready`, the word is accepted:
  - Next cycle: `pre_ld`=1, `pre_A = BASE + 4*index`, `pre_data = in_data`.
  - `checksum += in_data`; index increments.
  - Cycles with no accept give `pre_ld`=0 next cycle. `pre_A`/`pre_data` hold their last values.
- **LOAD to FLUSH:** taken on accepting the word with index `len-1`. FLUSH has `in_ready`=0, and its cycle carries the final `pre_ld` pulse.
- **FLUSH to DONE:** unconditional.
- **DONE:** `done`=1, `cpu_hold`=0. Held until `start` or reset.
- **ERR:** `err`=1, `cpu_hold`=1, nothing is written. Held until `start` or reset.
- **Ignored start:** `start` is ignored in LOAD and FLUSH.
- **Arithmetic:**
  - Index is 16 bits.
  - Address is computed in 32 bits, so there is no wrap inside the memory: the length check guarantees `pre_A+3 < N`.
  - Checksum wraps mod 2^32.

## Timing
- **Write latency:** each accepted word appears on `pre_ld`/`pre_A`/`pre_data` exactly 1 cycle after acceptance. Back-to-back accepts give back-to-back `pre_ld` pulses at +4 address steps. Throughput is 1 word/cycle.
- **Completion latency:** `done` rises, and `cpu_hold` falls, 2 cycles after the last accept (FLUSH, then DONE).
- **Checksum update:** `checksum` updates in the cycle after each accept, coincident with the `pre_ld` pulse.
- **`start` with `len == 0`:** `done`=1 one cycle after `start`. No `pre_ld`.
- **`start` with `len > MAXW`:** `err`=1 one cycle after `start`. `pre_ld` never asserts.
- **Reset mid-load:** immediate return to reset values and IDLE. Already-written words stay in memory. A pending registered `pre_ld` is cancelled asynchronously.
- **Stalled host:** `in_valid` low indefinitely in LOAD holds LOAD with `pre_ld`=0. There is no timeout.

## Structure
- **Package `imem_loader_pkg`:**
  - `loader_state_t` enum (IDLE, LOAD, FLUSH, DONE, ERR).
  - Constant `WORD_BYTES = 4`.
- **Module shape:** single module, with no sub-module.
- **Integration:** the top level instantiates `imem_boot_loader` next to `instruction_memory` with the same `N`. It connects `pre_ld`/`pre_A`/`pre_data` directly and routes `cpu_hold` to the datapath's PC-enable/reset logic.

## Test plan
- **Basic load:** reset, then `start`, `len`=3, feeding 0x11111111, 0x22222222, 0x33333333 back-to-back.
  - `pre_ld` pulses at `pre_A`=0, 4, 8.
  - Memory bytes 0..11 match little-endian.
  - `checksum`=0x66666666.
  - `done`=1 two cycles after last accept; `cpu_hold`=0.
- **Gapped input:** `BASE`=16, `len`=2, with `in_valid` toggling every other cycle.
  - Writes land at 16 and 20 only.
  - No `pre_ld` in gap cycles.
  - Words 0..15 untouched.
- **Overflow:** `N`=256, `len`=65.
  - `err`=1 next cycle; no `pre_ld` ever.
  - `cpu_hold`=1.
  - A following `start` with `len`=64 completes, writing the last word at 252.
- **Empty image:** `len`=0 gives `done`=1 next cycle, with no writes and `checksum`=0.
- **Reset mid-load:** assert `rst`=0 after 2 of 5 words.
  - All outputs return to reset values immediately; `in_ready`=0.
  - Words 0 and 1 remain in memory.
- **Reload and ignored start:** with `len`=2 and words 0xFFFFFFFF, 0x00000002, `checksum` wraps to 0x00000001. Then:
  - `start` pulsed during LOAD is ignored.
  - `start` in DONE clears `done` and `checksum` and restarts at `BASE`.
